priority_arbiter: RTL
=====================

// Module: priority_arbiter
//
// PURPOSE
// - Shares one resource between N_REQ requesters using a req/gnt handshake with registered grants.
// - Arbitration uses MSB-highest fixed priority, the same order as our priority encoder.
// - Grant is locked to its owner until the owner releases or MAX_HOLD expires.
// - Sits in front of shared datapaths such as a bus port or an encoder input bank.
//
// PARAMETERS
// - N_REQ     4                 number of requesters (>=2)
// - ID_W      $clog2(N_REQ)     width of gnt_id
// - MAX_HOLD  8                 max consecutive grant cycles per owner; 0 = unlimited
//
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - req        in   N_REQ  request lines; level, held until served
// - gnt        out  N_REQ  one-hot grant, registered
// - gnt_id     out  ID_W   binary index of current owner
// - gnt_valid  out  1      high when any gnt bit is high
//
// BEHAVIOUR
// - Reset (async assert, sync release): gnt=0, gnt_id=0, gnt_valid=0, state=IDLE, hold_cnt=0, last=0.
// - FSM states and transitions:
//   - IDLE: if |req, then next cycle state=GRANT and gnt=onehot(winner). Latency is 1 cycle from req to gnt.
//   - GRANT: owner keeps gnt. Release occurs when req[owner]==0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
//   - Release cycle: arbitrate the remaining requests combinationally.
//     - If one wins, the next cycle grants it with no bubble; stay in GRANT and clear hold_cnt.
//     - If none wins, the next cycle has gnt=0 and state=IDLE.
//   - A timeout excludes the owner from its own release arbitration.
//     - If it is the sole requester, gnt drops for 1 cycle, then it is re-granted through IDLE.
// - Winner: highest set index among eligible req (fixed priority).
// - hold_cnt: cleared on each new grant, +1 per GRANT cycle, never exceeds MAX_HOLD-1.
// - Requests rising during GRANT, including higher priority ones, are ignored until release. No preemption.
// - gnt is always one-hot or zero. gnt_id and gnt_valid always match gnt.
// - gnt_id holds its last value while gnt_valid=0.
// - Owner drop and another requester's rise in the same cycle: the riser is eligible in that release arbitration.
// - Reset mid-grant: all outputs clear immediately, with no clock required.
// - last: index of the most recent winner, updated on every new grant.
//
// CONFIGURATION
// - ROUND_ROBIN_EN defined: rotating priority.
//   - Search order is last-1, last-2, ... descending, wrapping modulo N_REQ; first set eligible req wins.
//   - The last owner becomes lowest priority.
//   - With last=0 after reset, the first search order is N_REQ-1 .. 0, identical to fixed priority.
// - ROUND_ROBIN_EN undefined: fixed MSB-highest priority. last is still tracked but unused.
// - Timeout exclusion rule applies in both modes.
//
// TESTING
// - IDLE, req=4'b0110: next cycle gnt=4'b0100, gnt_id=2, gnt_valid=1.
// - Owner 2 held, req 0110->0010: next cycle gnt=4'b0010, gnt_id=1, with no zero cycle between grants.
// - Owner 0 granted, then req=4'b1001: gnt stays 4'b0001 until req[0] drops, then the next cycle gives gnt=4'b1000.
// - MAX_HOLD=8, req=4'b1001 constant:
//   - gnt=4'b1000 for exactly 8 cycles, then 4'b0001 for 8 cycles, repeating.
// - MAX_HOLD=2, req=4'b1111 constant:
//   - fixed mode gives owner sequence 3,3,2,2,3,3,2,2.
//   - ROUND_ROBIN_EN gives 3,3,2,2,1,1,0,0,3.
// - rst_n low mid-grant, between clock edges: gnt=0, gnt_valid=0 immediately.
//   - After release with req=4'b0001: gnt=4'b0001 one cycle later.

Source files
------------

// File: rtl/priority_arbiter.sv
// priority_arbiter: N_REQ-way req/gnt arbiter with registered one-hot grant, grant locking and hold limit.
// Optional macro ROUND_ROBIN_EN selects rotating priority; default build is fixed MSB-highest priority.
module priority_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]  last_q, last_d;

  logic             timeout;
  logic             release_now;
  logic             arb_en;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] eligible;

`ifdef ROUND_ROBIN_EN
  // Search last-1, last-2, ... wrapping; the nearest set bit below last wins.
  function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] elig,
                                         input logic [ID_W-1:0]  last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + N_REQ - k) % N_REQ;
      if (elig[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction
`else
  function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] elig);
    logic [ID_W:0] res;
    res = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (elig[i]) res = {1'b1, ID_W'(i)};
    end
    return res;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    timeout     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    release_now = (state_q == GRANT) && (!req[gnt_id_q] || timeout);
    arb_en      = (state_q == IDLE) || release_now;

    // A timed-out owner may not win its own release arbitration.
    eligible = req;
    if ((state_q == GRANT) && timeout) eligible[gnt_id_q] = 1'b0;

`ifdef ROUND_ROBIN_EN
    {win_found, win_id} = pick(eligible, last_q);
`else
    {win_found, win_id} = pick(eligible);
`endif

    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;

    if (arb_en) begin
      if (win_found) begin
        state_d     = GRANT;
        gnt_d       = N_REQ'(1) << win_id;
        gnt_id_d    = win_id;
        gnt_valid_d = 1'b1;
        hold_cnt_d  = '0;
        last_d      = win_id;
      end else begin
        // gnt_id keeps the previous owner while nothing is granted.
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    end else if ((state_q == GRANT) && (MAX_HOLD != 0)) begin
      hold_cnt_d = hold_cnt_q + HC_W'(1);
    end
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_id    = gnt_id_q;
    gnt_valid = gnt_valid_q;
  end

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_valid  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_q == (|gnt_q));
  a_id     : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_q |-> gnt_q[gnt_id_q]);
`endif

endmodule
